// File: rtl/bus_hold_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_hold_arbiter_if
// Brief    : Bus-ownership signal bundle between the hold arbiter and the
//            CPU status / hold-requesting masters.
// Revision : 1.0  initial release
// ============================================================================
interface bus_hold_arbiter_if #(
  parameter int MASTERS = 2
);
  localparam int GRANT_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  logic [2:0]         processor_status;
  logic               processor_lock_n;
  logic [MASTERS-1:0] hold_request;
  logic [MASTERS-1:0] hold_acknowledge;
  logic [GRANT_W-1:0] grant_index;
  logic               address_enable_n;
  logic               dma_wait_n;
  logic               dma_enable;
  logic               hold_timeout;

  // The arbiter owns the bus-ownership outputs.
  modport master (
    input  processor_status, processor_lock_n, hold_request,
    output hold_acknowledge, grant_index, address_enable_n,
           dma_wait_n, dma_enable, hold_timeout
  );

  // CPU status source and hold requesters, consuming the ownership outputs.
  modport slave (
    output processor_status, processor_lock_n, hold_request,
    input  hold_acknowledge, grant_index, address_enable_n,
           dma_wait_n, dma_enable, hold_timeout
  );
endinterface
`default_nettype wire

// File: rtl/bus_hold_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_hold_arbiter
// Brief    : HOLD/HLDA bus-ownership arbiter handing the system bus from the
//            8088 CPU to one of MASTERS requesters, with round-robin or fixed
//            priority, a guaranteed CPU slot between grants, the AEN/DMA
//            enable chain and a grant-length monitor.
// Revision : 1.0  initial release
// ============================================================================
module bus_hold_arbiter #(
  parameter int MASTERS         = 2,
  parameter int ROUND_ROBIN     = 1,
  parameter int MIN_CPU_CYCLES  = 1,
  parameter int MAX_HOLD_CYCLES = 0
) (
  input  logic               clock,
  input  logic               reset,
  bus_hold_arbiter_if.master bus
);

  localparam int               c_GW        = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int               c_GWP       = c_GW + 1;
  localparam logic [c_GWP-1:0] c_MASTERS   = c_GWP'(MASTERS);
  localparam logic [c_GWP-1:0] c_ONE       = c_GWP'(1);
  localparam logic [3:0]       c_MIN_CPU   = 4'(MIN_CPU_CYCLES);
  localparam logic [15:0]      c_MAX_HOLD  = 16'(MAX_HOLD_CYCLES);
  localparam logic [15:0]      c_HOLD_SAT  = 16'hFFFF;

  localparam logic [1:0] S_CPU     = 2'd0;
  localparam logic [1:0] S_SYNC    = 2'd1;
  localparam logic [1:0] S_GRANT   = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [3:0]           r_cpu_cnt;
  logic [c_GW-1:0]      r_rr_ptr;
  logic [c_GW-1:0]      r_grant_index;
  logic [MASTERS-1:0]   r_hold_ack;
  logic                 r_aen;
  logic                 r_dma_wait;
  logic [15:0]          r_hold_cnt;
  logic                 r_timeout;

  logic                 w_cpu_idle;
  logic                 w_any_req;
  logic                 w_owner_req;
  logic                 w_in_cpu;
  logic                 w_in_grant;
  logic                 w_in_release;
  logic                 w_take_grant;
  logic                 w_drop_grant;
  logic                 w_hold_hit;

  logic [c_GW-1:0]      w_ptr;
  logic [2*MASTERS-1:0] w_req_shift;
  logic [MASTERS-1:0]   w_req_rot;
  logic [MASTERS-1:0]   w_scan;
  logic [c_GWP-1:0]     w_offset;
  logic [c_GWP-1:0]     w_sum;
  logic [c_GWP-1:0]     w_winner_ext;
  logic [c_GW-1:0]      w_winner;
  logic [c_GWP-1:0]     w_rr_inc;
  logic [c_GW-1:0]      w_rr_nxt;
  logic [MASTERS-1:0]   w_onehot;
  logic                 w_unused;

  // S2 is irrelevant to idle detection; passive status is S1:S0 = 11.
  assign w_cpu_idle  = (bus.processor_status[1:0] == 2'b11) & bus.processor_lock_n;
  assign w_any_req   = |bus.hold_request;
  // The acknowledge vector is one-hot on the owner while granted, so this
  // picks out the owner's request without a variable index.
  assign w_owner_req = |(bus.hold_request & r_hold_ack);
  assign w_ptr       = (ROUND_ROBIN != 0) ? r_rr_ptr : '0;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_CPU;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode: CPU slot gating, grant, no-preemption hold, release.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CPU:     if (w_any_req && w_cpu_idle && (r_cpu_cnt == c_MIN_CPU)) w_state_nxt = S_SYNC;
      S_SYNC:    w_state_nxt = w_any_req ? S_GRANT : S_CPU;
      S_GRANT:   if (!w_owner_req) w_state_nxt = S_RELEASE;
      S_RELEASE: w_state_nxt = S_CPU;
      default:   w_state_nxt = S_CPU;
    endcase
  end

  // Output decode: state-derived strobes that steer the datapath registers.
  always_comb begin
    w_in_cpu     = (r_state == S_CPU);
    w_in_grant   = (r_state == S_GRANT);
    w_in_release = (r_state == S_RELEASE);
    w_take_grant = (r_state == S_SYNC) && w_any_req;
    w_drop_grant = w_in_grant && !w_owner_req;
    w_hold_hit   = w_in_grant && (c_MAX_HOLD != 16'd0) && (r_hold_cnt != c_HOLD_SAT)
                   && ((r_hold_cnt + 16'd1) == c_MAX_HOLD);
  end

  // Winner search: rotate requests so the scan starts at bit 0, take the
  // lowest hit, then map it back to an absolute index modulo MASTERS.
  always_comb begin
    w_req_shift = {bus.hold_request, bus.hold_request} >> w_ptr;
    w_req_rot   = w_req_shift[MASTERS-1:0];
    w_offset    = '0;
    w_scan      = '0;
    for (int j = MASTERS - 1; j >= 0; j--) begin
      w_scan = w_req_rot >> j;
      if (w_scan[0]) w_offset = j[c_GWP-1:0];
    end
    w_sum        = {1'b0, w_ptr} + w_offset;
    w_winner_ext = (w_sum >= c_MASTERS) ? (w_sum - c_MASTERS) : w_sum;
    w_winner     = w_winner_ext[c_GW-1:0];
    w_rr_inc     = {1'b0, w_winner} + c_ONE;
    w_rr_nxt     = (w_rr_inc >= c_MASTERS) ? '0 : w_rr_inc[c_GW-1:0];
  end

  for (genvar gi = 0; gi < MASTERS; gi++) begin : g_onehot
    assign w_onehot[gi] = (w_winner == c_GW'(gi));
  end

  // Grant registers: latch winner, rotate priority, drop HLDA on release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hold_ack    <= '0;
      r_grant_index <= '0;
      r_rr_ptr      <= '0;
    end else if (w_take_grant) begin
      r_hold_ack    <= w_onehot;
      r_grant_index <= w_winner;
      r_rr_ptr      <= w_rr_nxt;
    end else if (w_drop_grant) begin
      r_hold_ack    <= '0;
    end
  end

  // CPU slot counter: restarts after each release, saturates at the minimum.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                   r_cpu_cnt <= c_MIN_CPU;
    else if (w_in_release)                       r_cpu_cnt <= 4'd0;
    else if (w_in_cpu && r_cpu_cnt != c_MIN_CPU) r_cpu_cnt <= r_cpu_cnt + 4'd1;
  end

  // Grant-length monitor: counts GRANT cycles, flags the threshold once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_hold_hit;
      if (w_take_grant)                            r_hold_cnt <= '0;
      else if (w_in_grant && r_hold_cnt != c_HOLD_SAT) r_hold_cnt <= r_hold_cnt + 16'd1;
    end
  end

  // AEN chain: AEN# follows HLDA by one edge, the DMA wait stage by another.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_aen      <= 1'b0;
      r_dma_wait <= 1'b0;
    end else begin
      r_aen      <= |r_hold_ack;
      r_dma_wait <= r_aen;
    end
  end

  assign bus.hold_acknowledge = r_hold_ack;
  assign bus.grant_index      = r_grant_index;
  assign bus.address_enable_n = r_aen;
  assign bus.dma_wait_n       = ~r_dma_wait;
  assign bus.dma_enable       = r_aen & r_dma_wait;
  assign bus.hold_timeout     = r_timeout;

  assign w_unused = ^{bus.processor_status[2], w_winner_ext[c_GW], w_req_shift, w_scan};

endmodule
`default_nettype wire

// File: tb/tb_bus_hold_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_hold_arbiter
// Brief    : Self-checking bench for bus_hold_arbiter. Three configurations
//            share CPU status/lock and are compared every cycle against a
//            behavioural model of the ownership rules, plus directed checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_bus_hold_arbiter;

  localparam int PH_CPU = 0, PH_SYNC = 1, PH_GRANT = 2, PH_RELEASE = 3;

  typedef struct {
    int         phase;
    int         cnt;
    int         ptr;
    int         gidx;
    logic [7:0] ack;
    bit         aen;
    bit         wt;
    int         hcnt;
    bit         tmo;
  } mdl_t;

  logic       clock;
  logic       reset;
  logic [2:0] status;
  logic       lock_n;
  logic [1:0] req_a;
  logic [2:0] req_b;
  logic [0:0] req_c;

  int         errors;
  int         checks;
  int         cyc;
  int         cfg_m   [3];
  int         cfg_rr  [3];
  int         cfg_min [3];
  int         cfg_max [3];
  mdl_t       mdl     [3];
  logic [13:0] obs    [3];

  bus_hold_arbiter_if #(.MASTERS(2)) if_a ();
  bus_hold_arbiter_if #(.MASTERS(3)) if_b ();
  bus_hold_arbiter_if #(.MASTERS(1)) if_c ();

  bus_hold_arbiter #(.MASTERS(2), .ROUND_ROBIN(1), .MIN_CPU_CYCLES(2), .MAX_HOLD_CYCLES(5))
    dut_a (.clock(clock), .reset(reset), .bus(if_a.master));
  bus_hold_arbiter #(.MASTERS(3), .ROUND_ROBIN(0), .MIN_CPU_CYCLES(1), .MAX_HOLD_CYCLES(0))
    dut_b (.clock(clock), .reset(reset), .bus(if_b.master));
  bus_hold_arbiter #(.MASTERS(1), .ROUND_ROBIN(1), .MIN_CPU_CYCLES(3), .MAX_HOLD_CYCLES(2))
    dut_c (.clock(clock), .reset(reset), .bus(if_c.master));

  assign if_a.processor_status = status;  assign if_a.processor_lock_n = lock_n;
  assign if_b.processor_status = status;  assign if_b.processor_lock_n = lock_n;
  assign if_c.processor_status = status;  assign if_c.processor_lock_n = lock_n;
  assign if_a.hold_request = req_a;
  assign if_b.hold_request = req_b;
  assign if_c.hold_request = req_c;

  assign obs[0] = {8'(if_a.hold_acknowledge), 3'(if_a.grant_index), if_a.address_enable_n,
                   if_a.dma_wait_n, if_a.dma_enable, if_a.hold_timeout};
  assign obs[1] = {8'(if_b.hold_acknowledge), 3'(if_b.grant_index), if_b.address_enable_n,
                   if_b.dma_wait_n, if_b.dma_enable, if_b.hold_timeout};
  assign obs[2] = {8'(if_c.hold_acknowledge), 3'(if_c.grant_index), if_c.address_enable_n,
                   if_c.dma_wait_n, if_c.dma_enable, if_c.hold_timeout};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------- model
  function automatic mdl_t mdl_reset(int mn);
    mdl_t s;
    s.phase = PH_CPU; s.cnt = mn; s.ptr = 0; s.gidx = 0; s.ack = 8'h00;
    s.aen = 1'b0; s.wt = 1'b0; s.hcnt = 0; s.tmo = 1'b0;
    return s;
  endfunction

  function automatic bit req_bit(logic [7:0] req, int i);
    return ((req >> i) & 8'h01) != 8'h00;
  endfunction

  // One clock edge of the ownership rules, from pre-edge state and inputs.
  function automatic mdl_t mdl_step(mdl_t s, logic [7:0] req, bit idle,
                                    int m, int rr, int mn, int mx);
    mdl_t n;
    int   w;
    int   i;
    n     = s;
    n.aen = (s.ack != 8'h00);
    n.wt  = s.aen;
    n.tmo = 1'b0;
    case (s.phase)
      PH_CPU: begin
        if (req != 8'h00 && idle && s.cnt == mn) n.phase = PH_SYNC;
        else if (s.cnt < mn)                     n.cnt   = s.cnt + 1;
      end
      PH_SYNC: begin
        if (req != 8'h00) begin
          w = -1;
          for (int k = 0; k < m; k++) begin
            i = (rr != 0) ? (s.ptr + k) % m : k;
            if (w < 0 && req_bit(req, i)) w = i;
          end
          n.gidx  = w;
          n.ack   = 8'h01 << w;
          n.ptr   = (w + 1) % m;
          n.hcnt  = 0;
          n.phase = PH_GRANT;
        end else begin
          n.phase = PH_CPU;
        end
      end
      PH_GRANT: begin
        n.tmo  = (mx != 0) && (s.hcnt < 65535) && (s.hcnt + 1 == mx);
        n.hcnt = (s.hcnt < 65535) ? s.hcnt + 1 : s.hcnt;
        if (!req_bit(req, s.gidx)) begin
          n.ack   = 8'h00;
          n.phase = PH_RELEASE;
        end
      end
      default: begin
        n.cnt   = 0;
        n.phase = PH_CPU;
      end
    endcase
    return n;
  endfunction

  function automatic logic [13:0] exp_vec(mdl_t s);
    logic [2:0] g;
    g = s.gidx[2:0];
    return {s.ack, g, s.aen, ~s.wt, s.aen & s.wt, s.tmo};
  endfunction

  function automatic logic [7:0] req_of(int k);
    case (k)
      0:       return 8'(req_a);
      1:       return 8'(req_b);
      default: return 8'(req_c);
    endcase
  endfunction

  // Randomly raise idle request lines and drop active ones.
  function automatic logic [7:0] churn(logic [7:0] v, int m);
    logic [7:0] r;
    logic [7:0] bm;
    r = v;
    for (int b = 0; b < m; b++) begin
      bm = 8'h01 << b;
      if ((v & bm) != 8'h00) begin
        if ($urandom_range(0, 5) == 0) r = r & ~bm;
      end else if ($urandom_range(0, 3) == 0) begin
        r = r | bm;
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- checks
  task automatic chk(string tag, logic [15:0] observed, logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, observed, expected);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++)
      chk($sformatf("model_dut%0d", k), 16'(obs[k]), 16'(exp_vec(mdl[k])));
  endtask

  task automatic tick();
    bit idle;
    @(posedge clock);
    idle = (status[1:0] == 2'b11) && lock_n;
    for (int k = 0; k < 3; k++) begin
      if (reset) mdl[k] = mdl_reset(cfg_min[k]);
      else       mdl[k] = mdl_step(mdl[k], req_of(k), idle, cfg_m[k], cfg_rr[k],
                                   cfg_min[k], cfg_max[k]);
    end
    cyc++;
    #1;
    check_all();
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int          grants_a [$];
    int          grants_b [$];
    logic [1:0]  prev_a;
    logic [2:0]  prev_b;
    logic [7:0]  tmp;
    int          pulses;
    int          ack_lost;

    errors = 0; checks = 0; cyc = 0;
    cfg_m   = '{2, 3, 1};
    cfg_rr  = '{1, 0, 1};
    cfg_min = '{2, 1, 3};
    cfg_max = '{5, 0, 2};
    reset = 1'b1; status = 3'b111; lock_n = 1'b1;
    req_a = '0; req_b = '0; req_c = '0;
    for (int k = 0; k < 3; k++) mdl[k] = mdl_reset(cfg_min[k]);

    // Reset values.
    #3;
    check_all();
    chk("reset_dma_wait_n", 16'(if_a.dma_wait_n), 16'd1);
    tick(); tick();
    reset = 1'b0;
    tick(); tick();

    // Single request: HLDA after 2 edges, AEN# after 3, dma_enable after 4.
    req_a = 2'b01; req_b = 3'b001; req_c = 1'b1;
    tick();
    chk("e0_no_hlda", 16'(if_a.hold_acknowledge), 16'd0);
    tick();
    chk("e1_hlda", 16'(if_a.hold_acknowledge), 16'h1);
    tick();
    chk("e2_aen", 16'(if_a.address_enable_n), 16'd1);
    chk("e2_dma_en_low", 16'(if_a.dma_enable), 16'd0);
    tick();
    chk("e3_dma_en", 16'({if_a.dma_enable, if_a.dma_wait_n}), 16'b10);
    tick(); tick();

    // Release sequence.
    req_a = '0; req_b = '0; req_c = '0;
    tick();
    chk("er_hlda_clear", 16'(if_a.hold_acknowledge), 16'd0);
    chk("er_aen_still", 16'(if_a.address_enable_n), 16'd1);
    tick();
    chk("er1_aen_dma", 16'({if_a.address_enable_n, if_a.dma_enable, if_a.dma_wait_n}), 16'b000);
    tick();
    chk("er2_wait_n", 16'(if_a.dma_wait_n), 16'd1);
    repeat (4) tick();

    // Rotation: each granted master drops its request right after HLDA.
    prev_a = '0; prev_b = '0;
    for (int c = 0; c < 40; c++) begin
      req_a = 2'b11  & ~if_a.hold_acknowledge;
      req_b = 3'b011 & ~if_b.hold_acknowledge;
      req_c = 1'b1   & ~if_c.hold_acknowledge;
      tick();
      if (prev_a == '0 && if_a.hold_acknowledge != '0) grants_a.push_back(int'(if_a.grant_index));
      if (prev_b == '0 && if_b.hold_acknowledge != '0) grants_b.push_back(int'(if_b.grant_index));
      prev_a = if_a.hold_acknowledge;
      prev_b = if_b.hold_acknowledge;
    end
    chk("rr_grant_count", 16'(grants_a.size() >= 4), 16'd1);
    chk("fixed_grant_count", 16'(grants_b.size() >= 3), 16'd1);
    // Master 0 held the last grant, so rotation resumes at master 1.
    if (grants_a.size() >= 4) begin
      chk("rr_g0", 16'(grants_a[0]), 16'd1);
      chk("rr_g1", 16'(grants_a[1]), 16'd0);
      chk("rr_g2", 16'(grants_a[2]), 16'd1);
      chk("rr_g3", 16'(grants_a[3]), 16'd0);
    end
    foreach (grants_b[i]) chk("fixed_always_0", 16'(grants_b[i]), 16'd0);
    req_a = '0; req_b = '0; req_c = '0;
    repeat (6) tick();

    // Status and lock gating.
    req_a = 2'b01; req_b = 3'b001; req_c = 1'b1;
    status = 3'b100;
    repeat (5) tick();
    chk("status_blocks", 16'(if_a.hold_acknowledge), 16'd0);
    status = 3'b111; lock_n = 1'b0;
    repeat (5) tick();
    chk("lock_blocks", 16'(if_a.hold_acknowledge), 16'd0);
    lock_n = 1'b1;
    tick(); tick();
    chk("unlock_grant", 16'(if_a.hold_acknowledge), 16'h1);

    // Hold monitor: one pulse, HLDA stays.
    pulses = 0; ack_lost = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (if_a.hold_timeout === 1'b1) pulses++;
      if (if_a.hold_acknowledge !== 2'b01) ack_lost++;
    end
    chk("timeout_pulses", 16'(pulses), 16'd1);
    chk("timeout_no_release", 16'(ack_lost), 16'd0);

    // Asynchronous reset mid-grant.
    chk("pre_reset_dma_en", 16'(if_a.dma_enable), 16'd1);
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) mdl[k] = mdl_reset(cfg_min[k]);
    check_all();
    chk("async_reset_outputs", 16'({if_a.hold_acknowledge, if_a.address_enable_n,
                                    if_a.dma_enable, if_a.dma_wait_n}), 16'b00001);
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("post_reset_grant", 16'(if_a.hold_acknowledge), 16'h1);
    req_a = '0; req_b = '0; req_c = '0;
    repeat (6) tick();

    // Single master: a one-cycle pulse seen in SYNC never produces HLDA.
    req_c = 1'b1;
    tick();
    req_c = 1'b0;
    tick();
    chk("pulse_sync_no_hlda", 16'(if_c.hold_acknowledge), 16'd0);
    tick(); tick();
    chk("pulse_no_late_hlda", 16'(if_c.hold_acknowledge), 16'd0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      status = ($urandom_range(0, 4) != 0) ? 3'b111 : 3'($urandom_range(0, 7));
      lock_n = ($urandom_range(0, 9) != 0);
      tmp = churn(8'(req_a), 2); req_a = tmp[1:0];
      tmp = churn(8'(req_b), 3); req_b = tmp[2:0];
      tmp = churn(8'(req_c), 1); req_c = tmp[0:0];
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
